// File: rtl/axi_lite_cfg_pkg.sv
// rtl/axi_lite_cfg_pkg.sv - shared types, response codes and width helper for the cfg sequencer
package axi_lite_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    WR_RESP,
    RD_RESP,
    RSP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Ceiling log2, used to size the timeout counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_cfg_sequencer_if.sv
// rtl/axi_lite_cfg_sequencer_if.sv - AXI-lite bus bundle with master/slave views
interface axi_lite_cfg_sequencer_if #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32
) ();

  logic             awvalid;
  logic             awready;
  logic [ASIZE-1:0] awaddr;
  logic             wvalid;
  logic             wready;
  logic [DSIZE-1:0] wdata;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [ASIZE-1:0] araddr;
  logic             rvalid;
  logic             rready;
  logic [DSIZE-1:0] rdata;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_timeout_cnt.sv
// rtl/axi_lite_timeout_cnt.sv - response-wait counter that flags expiry after TIMEOUT cycles
module axi_lite_timeout_cnt
  import axi_lite_cfg_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Count cycles spent waiting; held at zero whenever no response is awaited.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // TIMEOUT of zero means wait forever.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      assign expire = enable && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/axi_lite_cfg_sequencer.sv
// rtl/axi_lite_cfg_sequencer.sv - single-outstanding command-to-AXI-lite master with timeout
module axi_lite_cfg_sequencer
  import axi_lite_cfg_pkg::*;
#(
  parameter int ASIZE   = 32,
  parameter int DSIZE   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     axi_lite_aclk,
  input  logic                     axi_lite_reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ASIZE-1:0]         cmd_addr,
  input  logic [DSIZE-1:0]         cmd_wdata,
  output logic                     rsp_valid,
  output logic [DSIZE-1:0]         rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_timeout,
  output logic                     busy,
  axi_lite_cfg_sequencer_if.master axi
);

  state_t           state_q, state_d;
  logic             ready_en_q;
  logic [ASIZE-1:0] addr_q;
  logic [DSIZE-1:0] wdata_q;
  logic             aw_done_q, w_done_q;
  logic [DSIZE-1:0] rdata_q;
  logic [1:0]       resp_q;
  logic             timeout_q;
  logic             accept, aw_fin, w_fin, in_resp, tmo_expire;

  // cmd_ready is held low for the first cycle after reset.
  assign cmd_ready   = (state_q == IDLE) && ready_en_q;
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state_q != IDLE) || accept;

  assign axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign axi.arvalid = (state_q == RD_REQ);
  assign axi.awaddr  = addr_q;
  assign axi.araddr  = addr_q;
  assign axi.wdata   = wdata_q;
  // Idle keeps both readies high so stale beats are swallowed.
  assign axi.bready  = (state_q == IDLE) || (state_q == WR_RESP);
  assign axi.rready  = (state_q == IDLE) || (state_q == RD_RESP);

  assign aw_fin      = aw_done_q || (axi.awvalid && axi.awready);
  assign w_fin       = w_done_q  || (axi.wvalid && axi.wready);
  assign in_resp     = (state_q == WR_RESP) || (state_q == RD_RESP);

  assign rsp_valid   = (state_q == RSP);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;

  axi_lite_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (axi_lite_aclk),
    .rst    (axi_lite_reset),
    .clear  (!in_resp),
    .enable (in_resp),
    .expire (tmo_expire)
  );

  // State register.
  always_ff @(posedge axi_lite_aclk) begin
    if (axi_lite_reset) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state: a real beat wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_fin && w_fin) state_d = WR_RESP;
      RD_REQ:  if (axi.arready) state_d = RD_RESP;
      WR_RESP: if (axi.bvalid || tmo_expire) state_d = RSP;
      RD_RESP: if (axi.rvalid || tmo_expire) state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, per-channel write completion and response capture.
  always_ff @(posedge axi_lite_aclk) begin
    if (axi_lite_reset) begin
      ready_en_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= OKAY;
      timeout_q  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else if (state_q == WR_REQ) begin
        aw_done_q <= aw_fin;
        w_done_q  <= w_fin;
      end
      if ((state_q == WR_RESP) && (axi.bvalid || tmo_expire)) begin
        rdata_q   <= '0;
        resp_q    <= axi.bvalid ? axi.bresp : SLVERR;
        timeout_q <= !axi.bvalid;
      end
      if ((state_q == RD_RESP) && (axi.rvalid || tmo_expire)) begin
        rdata_q   <= axi.rvalid ? axi.rdata : '0;
        resp_q    <= axi.rvalid ? axi.rresp : SLVERR;
        timeout_q <= !axi.rvalid;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cfg_sequencer.sv
// tb/tb_axi_lite_cfg_sequencer.sv - scoreboard bench for the AXI-lite cfg sequencer
module tb_axi_lite_cfg_sequencer;
  import axi_lite_cfg_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic          busy;

  axi_lite_cfg_sequencer_if #(.ASIZE(AW), .DSIZE(DW)) axi ();

  axi_lite_cfg_sequencer #(.ASIZE(AW), .DSIZE(DW), .TIMEOUT(TMO)) dut (
    .axi_lite_aclk  (clk),
    .axi_lite_reset (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_resp       (rsp_resp),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy),
    .axi            (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          tmo;
    int            at;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [AW-1:0] aq[$];
  logic [DW-1:0] wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rsp_valid pops and compares one expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp rdata=%0h resp=%0h timeout=%0d, required no response",
                 rsp_rdata, rsp_resp, rsp_timeout);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_resp", rsp_resp, mon_e.resp);
        chk("rsp_timeout", rsp_timeout, mon_e.tmo);
        chk("rsp_cycle", cyc, mon_e.at);
      end
    end
  end

  // Slave model knobs and bookkeeping.
  int            aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [DW-1:0] r_data = '0;
  logic [1:0]    r_resp = 2'b00, b_resp = 2'b00;
  int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int            aw_hi = 0, w_hi = 0, b_beats = 0;
  bit            aw_got = 0, w_got = 0, ar_got = 0, b_acc = 0, r_acc = 0;

  // Slave: decides readies/valids mid-cycle; a beat offered here completes at the next edge.
  initial begin
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_acc = 0; r_acc = 0;
        aq.delete(); wq.delete();
      end else begin
        if (b_acc) begin axi.bvalid = 0; b_beats++; end
        if (r_acc) axi.rvalid = 0;
        if (aw_got && w_got && !axi.bvalid) begin
          if (b_dly >= 0 && b_cnt >= b_dly) begin
            axi.bvalid = 1; axi.bresp = b_resp; aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (ar_got && !axi.rvalid) begin
          if (r_cnt >= r_dly) begin
            axi.rvalid = 1; axi.rdata = r_data; axi.rresp = r_resp; ar_got = 0;
          end else r_cnt++;
        end
        axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
        if (axi.awvalid) begin
          aw_hi++;
          if (aq.size() > 0) chk("awaddr", axi.awaddr, aq[0]);
          if (axi.awready) begin aw_got = 1; aw_cnt = 0; void'(aq.pop_front()); end
          else aw_cnt++;
        end
        axi.wready = axi.wvalid && (w_cnt >= w_dly);
        if (axi.wvalid) begin
          w_hi++;
          if (wq.size() > 0) chk("wdata", axi.wdata, wq[0]);
          if (axi.wready) begin w_got = 1; w_cnt = 0; void'(wq.pop_front()); end
          else w_cnt++;
        end
        axi.arready = axi.arvalid && (ar_cnt >= ar_dly);
        if (axi.arvalid) begin
          if (aq.size() > 0) chk("araddr", axi.araddr, aq[0]);
          if (axi.arready) begin ar_got = 1; ar_cnt = 0; r_cnt = 0; void'(aq.pop_front()); end
          else ar_cnt++;
        end
        b_acc = axi.bvalid && axi.bready;
        r_acc = axi.rvalid && axi.rready;
      end
    end
  end

  // Offer a command and wait for accept; cmd_valid is left high for the caller to drop.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rd, input logic [1:0] exp_resp,
                          input logic exp_tmo, input int lat, input bit push,
                          input bit busy_chk, output int acc);
    int budget;
    budget = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    aq.push_back(addr);
    if (wr) wq.push_back(wdata);
    while (!cmd_ready && budget < 200) begin
      if (busy_chk) chk("busy_held", busy, 1);
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait: got no accept in 200 cycles, required cmd_ready");
      acc = -1;
    end else begin
      if (busy_chk) chk("busy_at_accept", busy, 1);
      acc = cyc;
      if (push) sb.push_back('{rdata: exp_rd, resp: exp_resp, tmo: exp_tmo, at: acc + lat});
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_wait: got %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  int acc1, acc2, beats0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_awvalid", axi.awvalid, 0);
    chk("reset_wvalid", axi.wvalid, 0);
    chk("reset_arvalid", axi.arvalid, 0);
    chk("reset_bready", axi.bready, 1);
    chk("reset_rready", axi.rready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    // Zero-wait write: AW/W at T1, B at T2, rsp at T3.
    aw_hi = 0; w_hi = 0;
    send_cmd(1, 32'h0000_0010, 32'hDEAD_BEEF, '0, OKAY, 0, 3, 1, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    wait_rsp();
    chk("w0_awvalid_cycles", aw_hi, 1);
    chk("w0_wvalid_cycles", w_hi, 1);

    // AW stalled: awvalid high 3 cycles, wvalid 1 cycle; rsp at T5.
    aw_hi = 0; w_hi = 0; aw_dly = 2;
    send_cmd(1, 32'h0000_0020, 32'hA5A5_0001, '0, OKAY, 0, 5, 1, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    wait_rsp();
    chk("w1_awvalid_cycles", aw_hi, 3);
    chk("w1_wvalid_cycles", w_hi, 1);
    aw_dly = 0;

    // Write with SLVERR from the slave.
    b_resp = SLVERR;
    send_cmd(1, 32'h0000_0024, 32'h0000_00FF, '0, SLVERR, 0, 3, 1, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    wait_rsp();
    b_resp = OKAY;

    // Read with delayed R carrying SLVERR.
    r_dly = 5; r_data = 32'h1234_5678; r_resp = 2'b10;
    send_cmd(0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h1234_5678, 2'b10, 0, 8, 1, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    wait_rsp();

    // Zero-wait read.
    r_dly = 0; r_data = 32'hCAFE_F00D; r_resp = OKAY;
    send_cmd(0, 32'h0000_0008, '0, 32'hCAFE_F00D, OKAY, 0, 3, 1, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    wait_rsp();

    // B never arrives: timeout after TMO waiting cycles, then a late B is drained silently.
    b_dly = -1;
    send_cmd(1, 32'h0000_0030, 32'h1111_2222, '0, SLVERR, 1, 2 + TMO, 1, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    wait_rsp();
    beats0 = b_beats;
    b_dly = 0;
    repeat (4) @(negedge clk);
    chk("late_b_drained", b_beats, beats0 + 1);

    // Back-to-back with cmd_valid held: next accept one cycle after rsp_valid.
    send_cmd(1, 32'h0000_0040, 32'h0000_0001, '0, OKAY, 0, 3, 1, 0, acc1);
    send_cmd(1, 32'h0000_0044, 32'h0000_0002, '0, OKAY, 0, 3, 1, 1, acc2);
    @(negedge clk) cmd_valid = 0;
    chk("b2b_accept_gap", acc2, acc1 + 4);
    wait_rsp();

    // Reset while arvalid waits for arready.
    ar_dly = 1000;
    send_cmd(0, 32'h0000_0050, '0, '0, OKAY, 0, 0, 0, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    chk("arvalid_pending", axi.arvalid, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 0; ar_dly = 0;
    @(negedge clk);
    chk("rst_release_ready", cmd_ready, 1);

    // Recovery read after the abort.
    r_data = 32'h0BAD_F00D;
    send_cmd(0, 32'h0000_0060, '0, 32'h0BAD_F00D, OKAY, 0, 3, 1, 0, acc1);
    @(negedge clk) cmd_valid = 0;
    wait_rsp();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
